// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the GFX
// scan-out engine and NCH CPU-side valid/ready masters.
//
//   clk, rst            clock, asynchronous active-high reset
//   gfx_active_i        GFX owns the RAM port this cycle (absolute priority)
//   gfx_addr_i          GFX read address
//   gfx_rdata_o         RAM read data, straight through
//   req_valid_i [NCH]   per-channel request, held until ready
//   req_addr_i/wdata_i/wstrb_i  per-channel slices; wstrb==0 means read
//   req_ready_o [NCH]   one-cycle completion pulse
//   req_rdata_o         read data of the last completed read
//   ram_*               RAM port (ce, byte we, addr, wdata, rdata)
//
// CPU requests are served one at a time, round-robin. Partial writes go to
// the RAM as byte enables when BYTE_WE=1, or as read-modify-write otherwise.
module vram_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 32,
  parameter int NCH     = 2,
  parameter int BYTE_WE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gfx_active_i,
  input  logic [AW-1:0]           gfx_addr_i,
  output logic [DW-1:0]           gfx_rdata_o,
  input  logic [NCH-1:0]          req_valid_i,
  input  logic [NCH*AW-1:0]       req_addr_i,
  input  logic [NCH*DW-1:0]       req_wdata_i,
  input  logic [NCH*(DW/8)-1:0]   req_wstrb_i,
  output logic [NCH-1:0]          req_ready_o,
  output logic [DW-1:0]           req_rdata_o,
  output logic                    ram_ce_o,
  output logic [DW/8-1:0]         ram_we_o,
  output logic [AW-1:0]           ram_addr_o,
  output logic [DW-1:0]           ram_wdata_o,
  input  logic [DW-1:0]           ram_rdata_i
);
  localparam int WB = DW / 8;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RDATA, S_MERGE, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [WB-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NCH-1:0]  ready_q, ready_d;

  logic            is_read, is_direct;
  logic [WB-1:0]   we_direct;
  int              idx, pick;
  logic            found;

  assign gfx_rdata_o = ram_rdata_i;
  assign req_ready_o = ready_q;
  assign req_rdata_o = rdata_q;

  assign is_read   = (wstrb_q == '0);
  // Direct write: full word, or any partial write when the RAM has byte enables.
  assign is_direct = (&wstrb_q) || ((BYTE_WE != 0) && !is_read);
  assign we_direct = (BYTE_WE != 0) ? wstrb_q : {WB{1'b1}};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    ready_d      = '0;
    ram_ce_o     = 1'b0;
    ram_we_o     = '0;
    ram_addr_o   = addr_q;
    ram_wdata_o  = wdata_q;
    idx          = 0;
    pick         = 0;
    found        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Rotating priority: search starts just after the last granted channel.
        for (int i = 0; i < NCH; i++) begin
          idx = (int'(last_grant_q) + 1 + i) % NCH;
          if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          grant_d      = CW'(pick);
          last_grant_d = CW'(pick);
          addr_d       = req_addr_i[pick*AW +: AW];
          wdata_d      = req_wdata_i[pick*DW +: DW];
          wstrb_d      = req_wstrb_i[pick*WB +: WB];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!gfx_active_i) begin
          ram_ce_o = 1'b1;
          if (is_read) begin
            state_d = S_RDATA;
          end else if (is_direct) begin
            ram_we_o = we_direct;
            state_d  = S_DONE;
          end else begin
            state_d = S_MERGE;  // fetch the old word first
          end
        end
      end
      S_RDATA: begin
        // Data of the previous cycle's read; valid even if GFX owns the port now.
        rdata_d = ram_rdata_i;
        state_d = S_DONE;
      end
      S_MERGE: begin
        for (int b = 0; b < WB; b++)
          wdata_d[b*8 +: 8] = wstrb_q[b] ? wdata_q[b*8 +: 8] : ram_rdata_i[b*8 +: 8];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!gfx_active_i) begin
          ram_ce_o = 1'b1;
          ram_we_o = {WB{1'b1}};
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) ready_d[grant_q] = 1'b1;

    // GFX overrides the port unconditionally; ISSUE/WRITE already stall then.
    if (gfx_active_i) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = '0;
      ram_addr_o = gfx_addr_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= CW'(NCH - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: instance 0 is word-only (BYTE_WE=0), instance 1 is
// byte-enabled. Each instance has its own RAM model and a shadow memory that
// is updated from the request rules whenever a request completes.
module tb_vram_arbiter;
  localparam int AW = 11, DW = 32, NCH = 2, WB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 gfx_active [2];
  logic [AW-1:0]        gfx_addr   [2];
  logic [DW-1:0]        gfx_rdata  [2];
  logic [NCH-1:0]       req_valid  [2];
  logic [NCH*AW-1:0]    req_addr   [2];
  logic [NCH*DW-1:0]    req_wdata  [2];
  logic [NCH*WB-1:0]    req_wstrb  [2];
  logic [NCH-1:0]       req_ready  [2];
  logic [DW-1:0]        req_rdata  [2];
  logic                 ram_ce     [2];
  logic [WB-1:0]        ram_we     [2];
  logic [AW-1:0]        ram_addr   [2];
  logic [DW-1:0]        ram_wdata  [2];
  logic [DW-1:0]        ram_rdata  [2];

  vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .BYTE_WE(0)) dut0 (
    .clk(clk), .rst(rst), .gfx_active_i(gfx_active[0]), .gfx_addr_i(gfx_addr[0]),
    .gfx_rdata_o(gfx_rdata[0]), .req_valid_i(req_valid[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .req_wstrb_i(req_wstrb[0]), .req_ready_o(req_ready[0]),
    .req_rdata_o(req_rdata[0]), .ram_ce_o(ram_ce[0]), .ram_we_o(ram_we[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]));

  vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH), .BYTE_WE(1)) dut1 (
    .clk(clk), .rst(rst), .gfx_active_i(gfx_active[1]), .gfx_addr_i(gfx_addr[1]),
    .gfx_rdata_o(gfx_rdata[1]), .req_valid_i(req_valid[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .req_wstrb_i(req_wstrb[1]), .req_ready_o(req_ready[1]),
    .req_rdata_o(req_rdata[1]), .ram_ce_o(ram_ce[1]), .ram_we_o(ram_we[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]));

  logic [DW-1:0] mem     [2][32];
  logic [DW-1:0] ref_mem [2][32];
  int            ce_cnt [2], we_cnt [2], bad_we [2];
  logic [WB-1:0] last_we [2];
  logic          gfx_seen [2];
  logic [4:0]    gfx_a    [2];
  int            n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd,
                                          logic [WB-1:0] ws);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < WB; b++) if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Synchronous single-port RAM models with byte enables.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      gfx_seen[k] = gfx_active[k];
      gfx_a[k]    = gfx_addr[k][4:0];
      if (ram_ce[k]) begin
        if (!rst) ce_cnt[k]++;
        if (ram_we[k] == '0) begin
          ram_rdata[k] <= mem[k][ram_addr[k][4:0]];
        end else begin
          we_cnt[k]++;
          last_we[k] = ram_we[k];
          if (k == 0 && ram_we[k] != '1) bad_we[k]++;
          for (int b = 0; b < WB; b++)
            if (ram_we[k][b]) mem[k][ram_addr[k][4:0]][b*8 +: 8] = ram_wdata[k][b*8 +: 8];
        end
      end
    end
  end

  // GFX reads issued last cycle must return the current memory contents.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (gfx_seen[k]) chk("gfx_rdata", gfx_rdata[k], ref_mem[k][gfx_a[k]]);
  end

  task automatic preload(int k, int a, logic [DW-1:0] d);
    mem[k][a] = d;
    ref_mem[k][a] = d;
  endtask

  // One request on an idle arbiter; called just after a rising edge (= cycle 0).
  task automatic single(int k, int ch, logic [AW-1:0] a, logic [DW-1:0] wd, logic [WB-1:0] ws,
                        int gfx_cyc, int exp_lat, int exp_ce, int exp_we, string tag);
    int cyc;
    bit done;
    logic [DW-1:0] old;
    old = ref_mem[k][a[4:0]];
    ce_cnt[k] = 0; we_cnt[k] = 0;
    req_valid[k][ch] = 1'b1;
    req_addr[k][ch*AW +: AW]  = a;
    req_wdata[k][ch*DW +: DW] = wd;
    req_wstrb[k][ch*WB +: WB] = ws;
    gfx_active[k] = (gfx_cyc > 0);
    gfx_addr[k]   = AW'($urandom_range(0, 31));
    cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (req_ready[k] != '0) begin
        done = 1;
        chk({tag, "_ready"}, req_ready[k], 64'(1 << ch));
      end else begin
        @(posedge clk); #1;
        cyc++;
        gfx_active[k] = (cyc < gfx_cyc);
        gfx_addr[k]   = AW'($urandom_range(0, 31));
      end
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    if (done) begin
      if (ws == '0) chk({tag, "_rdata"}, req_rdata[k], old);
      else ref_mem[k][a[4:0]] = merge(old, wd, ws);
    end
    @(posedge clk); #1;
    req_valid[k][ch] = 1'b0;
    gfx_active[k] = 1'b0;
    chk({tag, "_mem"}, mem[k][a[4:0]], ref_mem[k][a[4:0]]);
    if (exp_ce >= 0) chk({tag, "_ce_cycles"}, ce_cnt[k], exp_ce);
    if (exp_we >= 0) chk({tag, "_we_cycles"}, we_cnt[k], exp_we);
  endtask

  // Free-running masters on all channels; reads checked against the shadow.
  task automatic traffic(int k, int nreq, int pct, int gpct, bit chk_order, string tag);
    int issued, done_n, cyc, r;
    logic [AW-1:0] pa [NCH];
    logic [DW-1:0] pd [NCH];
    logic [WB-1:0] ps [NCH];
    bit drop [NCH];
    issued = 0; done_n = 0; cyc = 0;
    for (int c = 0; c < NCH; c++) drop[c] = 0;
    while (done_n < nreq && cyc < 5000) begin
      for (int c = 0; c < NCH; c++) if (drop[c]) begin req_valid[k][c] = 1'b0; drop[c] = 0; end
      for (int c = 0; c < NCH; c++) begin
        if (!req_valid[k][c] && issued < nreq && $urandom_range(0, 99) < pct) begin
          pa[c] = AW'($urandom_range(0, 15));
          pd[c] = $urandom;
          r = $urandom_range(0, 3);
          ps[c] = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : WB'($urandom_range(1, 14));
          req_valid[k][c] = 1'b1;
          req_addr[k][c*AW +: AW]  = pa[c];
          req_wdata[k][c*DW +: DW] = pd[c];
          req_wstrb[k][c*WB +: WB] = ps[c];
          issued++;
        end
      end
      gfx_active[k] = ($urandom_range(0, 99) < gpct);
      gfx_addr[k]   = AW'($urandom_range(0, 15));
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (req_ready[k][c]) begin
          if (ps[c] == '0) chk({tag, "_rdata"}, req_rdata[k], ref_mem[k][pa[c][4:0]]);
          else ref_mem[k][pa[c][4:0]] = merge(ref_mem[k][pa[c][4:0]], pd[c], ps[c]);
          if (chk_order) chk({tag, "_grant"}, c, done_n % NCH);
          done_n++;
          drop[c] = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_completed"}, done_n, nreq);
    req_valid[k] = '0;
    gfx_active[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) preload(k, a, $urandom);
      gfx_active[k] = 1'b0; gfx_addr[k] = '0;
      req_valid[k] = '0; req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
      ce_cnt[k] = 0; we_cnt[k] = 0; bad_we[k] = 0; last_we[k] = '0;
      gfx_seen[k] = 1'b0; gfx_a[k] = '0;
    end
    rst = 1'b1;
    // GFX port stays combinational while in reset.
    gfx_active[0] = 1'b1; gfx_addr[0] = AW'(5);
    #2;
    chk("rst_gfx_ce", ram_ce[0], 1);
    chk("rst_gfx_addr", ram_addr[0], 5);
    chk("rst_gfx_we", ram_we[0], 0);
    chk("rst_ready", {req_ready[1], req_ready[0]}, 0);
    chk("rst_rdata", req_rdata[0], 0);
    gfx_active[0] = 1'b0;
    #1 chk("rst_ce_idle", ram_ce[0], 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    preload(0, 'h005, 32'hDEADBEEF);
    single(0, 0, 11'h005, 32'h0, 4'h0, 0, 3, 1, 0, "read");
    preload(0, 'h010, 32'h11223344);
    single(0, 1, 11'h010, 32'hAABBCCDD, 4'b0010, 0, 4, 2, 1, "rmw");
    chk("rmw_result", mem[0][16], 32'h1122CC44);
    preload(1, 'h010, 32'h11223344);
    single(1, 1, 11'h010, 32'hAABBCCDD, 4'b0010, 0, 2, 1, 1, "bytewe");
    chk("bytewe_we", last_we[1], 4'b0010);
    chk("bytewe_result", mem[1][16], 32'h1122CC44);
    single(0, 0, 11'h007, 32'h01234567, 4'hF, 0, 2, 1, 1, "fullwr");
    single(0, 0, 11'h008, 32'h89ABCDEF, 4'hF, 20, 21, -1, 1, "preempt_wr");
    single(0, 1, 11'h009, 32'h55667788, 4'b1001, 5, 8, -1, 1, "preempt_rmw");
    single(0, 0, 11'h009, 32'h0, 4'h0, 3, 5, -1, 0, "preempt_rd");

    // Reset while the RMW sits in MERGE: nothing may be written.
    preload(0, 'h010, 32'h11223344);
    req_valid[0][1] = 1'b1;
    req_addr[0][AW +: AW] = 11'h010;
    req_wdata[0][DW +: DW] = 32'hAABBCCDD;
    req_wstrb[0][WB +: WB] = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; we_cnt[0] = 0;
    #1 chk("rstmid_ready", req_ready[0], 0);
    @(posedge clk); #1 req_valid[0] = '0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_we", we_cnt[0], 0);
    chk("rstmid_mem", mem[0][16], 32'h11223344);
    chk("rstmid_rdata", req_rdata[0], 0);
    single(0, 0, 11'h010, 32'h0, 4'h0, 0, 3, 1, 0, "after_rst");

    do_reset();
    traffic(0, 6, 100, 0, 1, "fair0");
    traffic(1, 6, 100, 0, 1, "fair1");
    traffic(0, 60, 40, 30, 0, "rand0");
    traffic(1, 60, 40, 30, 0, "rand1");
    chk("word_only_we", bad_we[0], 0);
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 16; a++) chk("final_mem", mem[k][a], ref_mem[k][a]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
